// File: rtl/video_stream_arbiter.sv
// Two-source packet arbiter feeding one video stream: grants whole packets (SOP..EOP),
// latches the granted source's frame geometry, and discards stray non-SOP beats while idle.
module video_stream_arbiter #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            sel_mode,
    input  logic [15:0]           s0_width,
    input  logic [15:0]           s0_height,
    input  logic [3:0]            s0_interlaced,
    input  logic [15:0]           s1_width,
    input  logic [15:0]           s1_height,
    input  logic [3:0]            s1_interlaced,
    input  logic [DATA_WIDTH-1:0] din0_data,
    input  logic                  din0_valid,
    input  logic                  din0_startofpacket,
    input  logic                  din0_endofpacket,
    output logic                  din0_ready,
    input  logic [DATA_WIDTH-1:0] din1_data,
    input  logic                  din1_valid,
    input  logic                  din1_startofpacket,
    input  logic                  din1_endofpacket,
    output logic                  din1_ready,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_valid,
    output logic                  dout_startofpacket,
    output logic                  dout_endofpacket,
    input  logic                  dout_ready,
    output logic [15:0]           video_width,
    output logic [15:0]           video_height,
    output logic [3:0]            video_interlaced,
    output logic [1:0]            grant,
    output logic [15:0]           drop_cnt
);

    typedef enum logic [2:0] {
        StIdle = 3'b001,
        StGnt0 = 3'b010,
        StGnt1 = 3'b100
    } state_e;

    state_e      state_q;
    logic        last_q;  // 1 = source 1 was granted last
    logic [1:0]  grant_q;
    logic [15:0] width_q;
    logic [15:0] height_q;
    logic [3:0]  interlaced_q;
    logic [15:0] drop_q;

    logic        req0, req1, pick0, pick1;
    logic        drop0, drop1;
    logic [16:0] drop_sum;
    logic [15:0] drop_d;
    logic        eop0_done, eop1_done;

    always_comb begin
        req0      = din0_valid & din0_startofpacket & ((sel_mode == 2'd0) | (sel_mode == 2'd1));
        req1      = din1_valid & din1_startofpacket & ((sel_mode == 2'd0) | (sel_mode == 2'd2));
        // On a tie the source not granted last wins
        pick0     = req0 & (~req1 | last_q);
        pick1     = req1 & ~pick0;
        drop0     = din0_valid & ~din0_startofpacket;
        drop1     = din1_valid & ~din1_startofpacket;
        drop_sum  = {1'b0, drop_q} + 17'(drop0) + 17'(drop1);
        drop_d    = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        eop0_done = din0_valid & dout_ready & din0_endofpacket;
        eop1_done = din1_valid & dout_ready & din1_endofpacket;
    end

    // Idle holds SOP beats at their source and swallows anything else that is valid
    always_comb begin
        dout_data          = '0;
        dout_valid         = 1'b0;
        dout_startofpacket = 1'b0;
        dout_endofpacket   = 1'b0;
        din0_ready         = ~(din0_valid & din0_startofpacket);
        din1_ready         = ~(din1_valid & din1_startofpacket);
        case (state_q)
            StGnt0: begin
                dout_data          = din0_data;
                dout_valid         = din0_valid;
                dout_startofpacket = din0_startofpacket;
                dout_endofpacket   = din0_endofpacket;
                din0_ready         = dout_ready;
                din1_ready         = 1'b0;
            end
            StGnt1: begin
                dout_data          = din1_data;
                dout_valid         = din1_valid;
                dout_startofpacket = din1_startofpacket;
                dout_endofpacket   = din1_endofpacket;
                din0_ready         = 1'b0;
                din1_ready         = dout_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_q       <= 1'b1;
            grant_q      <= 2'b00;
            width_q      <= '0;
            height_q     <= '0;
            interlaced_q <= '0;
            drop_q       <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    drop_q <= drop_d;
                    if (pick0) begin
                        state_q      <= StGnt0;
                        grant_q      <= 2'b01;
                        last_q       <= 1'b0;
                        width_q      <= s0_width;
                        height_q     <= s0_height;
                        interlaced_q <= s0_interlaced;
                    end else if (pick1) begin
                        state_q      <= StGnt1;
                        grant_q      <= 2'b10;
                        last_q       <= 1'b1;
                        width_q      <= s1_width;
                        height_q     <= s1_height;
                        interlaced_q <= s1_interlaced;
                    end
                end
                StGnt0: begin
                    if (eop0_done) begin
                        state_q <= StIdle;
                        grant_q <= 2'b00;
                    end
                end
                StGnt1: begin
                    if (eop1_done) begin
                        state_q <= StIdle;
                        grant_q <= 2'b00;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

    assign grant            = grant_q;
    assign video_width      = width_q;
    assign video_height     = height_q;
    assign video_interlaced = interlaced_q;
    assign drop_cnt         = drop_q;

endmodule

// File: tb/tb_video_stream_arbiter.sv
// Self-checking bench for video_stream_arbiter: directed scenarios plus a randomized run
// compared cycle by cycle against a packet-level reference model.
module tb_video_stream_arbiter;

    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    sel_mode;
    logic [15:0]   s0_width, s0_height, s1_width, s1_height;
    logic [3:0]    s0_interlaced, s1_interlaced;
    logic [DW-1:0] din0_data, din1_data, dout_data;
    logic          din0_valid, din0_startofpacket, din0_endofpacket, din0_ready;
    logic          din1_valid, din1_startofpacket, din1_endofpacket, din1_ready;
    logic          dout_valid, dout_startofpacket, dout_endofpacket, dout_ready;
    logic [15:0]   video_width, video_height, drop_cnt;
    logic [3:0]    video_interlaced;
    logic [1:0]    grant;

    int total = 0;
    int bad   = 0;

    // Reference model: owner 0 = nobody, 1 = source 0, 2 = source 1
    int          m_own;
    int          m_last;
    int          m_drop;
    logic [15:0] m_vw, m_vh;
    logic [3:0]  m_vi;

    video_stream_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .sel_mode(sel_mode),
        .s0_width(s0_width), .s0_height(s0_height), .s0_interlaced(s0_interlaced),
        .s1_width(s1_width), .s1_height(s1_height), .s1_interlaced(s1_interlaced),
        .din0_data(din0_data), .din0_valid(din0_valid),
        .din0_startofpacket(din0_startofpacket), .din0_endofpacket(din0_endofpacket),
        .din0_ready(din0_ready),
        .din1_data(din1_data), .din1_valid(din1_valid),
        .din1_startofpacket(din1_startofpacket), .din1_endofpacket(din1_endofpacket),
        .din1_ready(din1_ready),
        .dout_data(dout_data), .dout_valid(dout_valid),
        .dout_startofpacket(dout_startofpacket), .dout_endofpacket(dout_endofpacket),
        .dout_ready(dout_ready),
        .video_width(video_width), .video_height(video_height),
        .video_interlaced(video_interlaced), .grant(grant), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        sel_mode = 2'd0; dout_ready = 1'b1;
        s0_width = '0; s0_height = '0; s0_interlaced = '0;
        s1_width = '0; s1_height = '0; s1_interlaced = '0;
        din0_data = '0; din0_valid = 1'b0; din0_startofpacket = 1'b0; din0_endofpacket = 1'b0;
        din1_data = '0; din1_valid = 1'b0; din1_startofpacket = 1'b0; din1_endofpacket = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_own = 0; m_last = 1; m_drop = 0; m_vw = '0; m_vh = '0; m_vi = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        din0_valid = 1'b1; din0_startofpacket = 1'b1;
        din1_valid = 1'b1;
        #3;
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant: got %b want 00", grant); end
        total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
        total++; if (video_width !== 16'd0 || video_height !== 16'd0 || video_interlaced !== 4'd0) begin
            bad++; $display("FAIL reset_video: got %0d/%0d/%0d want 0/0/0", video_width, video_height, video_interlaced); end
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset_dout_valid: got %b want 0", dout_valid); end
        total++; if (din0_ready !== 1'b0) begin bad++; $display("FAIL reset_ready0: got %b want 0", din0_ready); end
        total++; if (din1_ready !== 1'b1) begin bad++; $display("FAIL reset_ready1: got %b want 1", din1_ready); end
        @(negedge clk);
        total++; if (drop_cnt !== 16'd0 || grant !== 2'b00) begin
            bad++; $display("FAIL reset_hold: got drop=%0d grant=%b want 0/00", drop_cnt, grant); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_inputs();
    endtask

    task automatic test_single_source();
        do_reset();
        s0_width = 16'd640; s0_height = 16'd480;
        din0_valid = 1'b1; din0_startofpacket = 1'b1; din0_data = 8'hA0;
        @(negedge clk);
        total++; if (grant !== 2'b00 || din0_ready !== 1'b0 || dout_valid !== 1'b0) begin
            bad++; $display("FAIL single_idle: got grant=%b rdy=%b dv=%b want 00/0/0", grant, din0_ready, dout_valid); end
        tick();
        for (int i = 0; i < 6; i++) begin
            din0_data = 8'hA0 + 8'(i);
            din0_startofpacket = (i == 0);
            din0_endofpacket = (i == 5);
            if (i == 1) s0_width = 16'd800;
            @(negedge clk);
            total++; if (grant !== 2'b01 || din0_ready !== 1'b1 || dout_valid !== 1'b1) begin
                bad++; $display("FAIL single_beat%0d_ctl: got grant=%b rdy=%b dv=%b want 01/1/1", i, grant, din0_ready, dout_valid); end
            total++; if (dout_data !== 8'hA0 + 8'(i) || dout_startofpacket !== (i == 0) || dout_endofpacket !== (i == 5)) begin
                bad++; $display("FAIL single_beat%0d_data: got %h sop=%b eop=%b want %h", i, dout_data, dout_startofpacket, dout_endofpacket, 8'hA0 + 8'(i)); end
            total++; if (video_width !== 16'd640 || video_height !== 16'd480) begin
                bad++; $display("FAIL single_video%0d: got %0dx%0d want 640x480", i, video_width, video_height); end
            tick();
        end
        din0_valid = 1'b0; din0_endofpacket = 1'b0;
        @(negedge clk);
        total++; if (grant !== 2'b00 || dout_valid !== 1'b0) begin
            bad++; $display("FAIL single_after_eop: got grant=%b dv=%b want 00/0", grant, dout_valid); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g [6];
        exp_g = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
        do_reset();
        din0_valid = 1'b1; din0_startofpacket = 1'b1; din0_endofpacket = 1'b1; din0_data = 8'h11;
        din1_valid = 1'b1; din1_startofpacket = 1'b1; din1_endofpacket = 1'b1; din1_data = 8'h22;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++; if (grant !== exp_g[i]) begin
                bad++; $display("FAIL rr_grant%0d: got %b want %b", i, grant, exp_g[i]); end
            if (exp_g[i] == 2'b00) begin
                total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL rr_gap%0d: got dv=%b want 0", i, dout_valid); end
            end else begin
                total++; if (dout_data !== (exp_g[i] == 2'b01 ? 8'h11 : 8'h22)) begin
                    bad++; $display("FAIL rr_data%0d: got %h want %h", i, dout_data, (exp_g[i] == 2'b01 ? 8'h11 : 8'h22)); end
            end
            tick();
        end
    endtask

    task automatic test_stray_beats();
        do_reset();
        din1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din1_data = 8'($urandom);
            @(negedge clk);
            total++; if (din1_ready !== 1'b1 || dout_valid !== 1'b0) begin
                bad++; $display("FAIL stray_beat%0d: got rdy=%b dv=%b want 1/0", i, din1_ready, dout_valid); end
            tick();
        end
        din1_valid = 1'b0;
        @(negedge clk);
        total++; if (drop_cnt !== 16'd3) begin bad++; $display("FAIL stray_count: got %0d want 3", drop_cnt); end
        tick();
        din0_valid = 1'b1; din1_valid = 1'b1;
        tick();
        din0_valid = 1'b0; din1_valid = 1'b0;
        @(negedge clk);
        total++; if (drop_cnt !== 16'd5) begin bad++; $display("FAIL stray_dual: got %0d want 5", drop_cnt); end
    endtask

    task automatic test_saturation();
        do_reset();
        sel_mode = 2'd3;
        din0_valid = 1'b1; din1_valid = 1'b1;
        repeat (32767) tick();
        @(negedge clk);
        total++; if (drop_cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_pre: got %h want fffe", drop_cnt); end
        tick();
        @(negedge clk);
        total++; if (drop_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_clip: got %h want ffff", drop_cnt); end
        tick();
        @(negedge clk);
        total++; if (drop_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold: got %h want ffff", drop_cnt); end
        tick();
    endtask

    task automatic test_backpressure_mode();
        logic [7:0] got [$];
        int idx = 0;
        int cyc = 0;
        logic acc;
        do_reset();
        din0_valid = 1'b1; din0_startofpacket = 1'b1; din0_data = 8'h50;
        din1_valid = 1'b1; din1_startofpacket = 1'b1; din1_data = 8'h60;
        dout_ready = 1'b0;
        @(negedge clk);
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL bp_idle: got %b want 00", grant); end
        tick();
        while (idx < 5 && cyc < 40) begin
            din0_data = 8'h50 + 8'(idx);
            din0_startofpacket = (idx == 0);
            din0_endofpacket = (idx == 4);
            dout_ready = (cyc % 2 == 0);
            if (idx == 2) sel_mode = 2'd2;
            @(negedge clk);
            total++; if (grant !== 2'b01 || din0_ready !== dout_ready || din1_ready !== 1'b0) begin
                bad++; $display("FAIL bp_ctl%0d: got grant=%b rdy0=%b rdy1=%b want 01/%b/0", cyc, grant, din0_ready, din1_ready, dout_ready); end
            total++; if (dout_valid !== 1'b1 || dout_data !== 8'h50 + 8'(idx)) begin
                bad++; $display("FAIL bp_data%0d: got dv=%b %h want 1/%h", cyc, dout_valid, dout_data, 8'h50 + 8'(idx)); end
            acc = dout_valid && dout_ready;
            if (acc) got.push_back(dout_data);
            tick();
            if (acc) idx++;
            cyc++;
        end
        total++; if (idx != 5) begin bad++; $display("FAIL bp_timeout: got %0d beats want 5", idx); end
        total++; if (got.size() != 5) begin bad++; $display("FAIL bp_count: got %0d want 5", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            total++; if (got[i] !== 8'h50 + 8'(i)) begin bad++; $display("FAIL bp_beat%0d: got %h want %h", i, got[i], 8'h50 + 8'(i)); end
        end
        din0_startofpacket = 1'b1; din0_endofpacket = 1'b0; din0_data = 8'h70;
        dout_ready = 1'b1;
        @(negedge clk);
        total++; if (grant !== 2'b00 || dout_valid !== 1'b0 || din0_ready !== 1'b0) begin
            bad++; $display("FAIL bp_gap: got grant=%b dv=%b rdy0=%b want 00/0/0", grant, dout_valid, din0_ready); end
        tick();
        @(negedge clk);
        total++; if (grant !== 2'b10 || dout_data !== 8'h60) begin
            bad++; $display("FAIL bp_next_grant: got %b data=%h want 10/60", grant, dout_data); end
    endtask

    task automatic test_pause_reset();
        do_reset();
        sel_mode = 2'd3;
        din0_valid = 1'b1;
        tick(); tick();
        din0_startofpacket = 1'b1;
        din1_valid = 1'b1; din1_startofpacket = 1'b1; din1_data = 8'h33;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if (grant !== 2'b00 || din0_ready !== 1'b0 || din1_ready !== 1'b0 || dout_valid !== 1'b0) begin
                bad++; $display("FAIL pause%0d: got grant=%b rdy=%b%b dv=%b want 00/00/0", i, grant, din1_ready, din0_ready, dout_valid); end
            tick();
        end
        total++; if (drop_cnt !== 16'd2) begin bad++; $display("FAIL pause_drop: got %0d want 2", drop_cnt); end
        s1_width = 16'd1920; s1_height = 16'd1080; s1_interlaced = 4'hA;
        sel_mode = 2'd2;
        tick();
        @(negedge clk);
        total++; if (grant !== 2'b10 || video_width !== 16'd1920 || video_interlaced !== 4'hA) begin
            bad++; $display("FAIL pause_grant1: got %b %0d %h want 10 1920 a", grant, video_width, video_interlaced); end
        tick();
        din1_startofpacket = 1'b0; din1_data = 8'h34;
        #2 rst_n = 1'b0;
        #1;
        total++; if (grant !== 2'b00 || drop_cnt !== 16'd0) begin
            bad++; $display("FAIL midrst_state: got grant=%b drop=%0d want 00/0", grant, drop_cnt); end
        total++; if (video_width !== 16'd0 || video_height !== 16'd0 || video_interlaced !== 4'd0) begin
            bad++; $display("FAIL midrst_video: got %0d/%0d/%0d want 0/0/0", video_width, video_height, video_interlaced); end
        total++; if (dout_valid !== 1'b0 || din1_ready !== 1'b1) begin
            bad++; $display("FAIL midrst_stream: got dv=%b rdy1=%b want 0/1", dout_valid, din1_ready); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_inputs();
        @(negedge clk);
        total++; if (dout_valid !== 1'b0 || grant !== 2'b00) begin
            bad++; $display("FAIL midrst_after: got dv=%b grant=%b want 0/00", dout_valid, grant); end
        tick();
    endtask

    task automatic test_random();
        logic          e_dv, e_sop, e_eop, e_r0, e_r1;
        logic [DW-1:0] e_data;
        logic [1:0]    e_g;
        bit            r0, r1;
        int            win;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) sel_mode = 2'($urandom);
            s0_width = 16'($urandom); s0_height = 16'($urandom); s0_interlaced = 4'($urandom);
            s1_width = 16'($urandom); s1_height = 16'($urandom); s1_interlaced = 4'($urandom);
            din0_data = 8'($urandom); din1_data = 8'($urandom);
            din0_valid = ($urandom_range(0, 9) < 7);
            din0_startofpacket = ($urandom_range(0, 9) < 3);
            din0_endofpacket = ($urandom_range(0, 9) < 3);
            din1_valid = ($urandom_range(0, 9) < 7);
            din1_startofpacket = ($urandom_range(0, 9) < 3);
            din1_endofpacket = ($urandom_range(0, 9) < 3);
            dout_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            e_sop = 1'b0; e_eop = 1'b0; e_data = '0;
            if (m_own == 1) begin
                e_g = 2'b01; e_dv = din0_valid; e_data = din0_data;
                e_sop = din0_startofpacket; e_eop = din0_endofpacket;
                e_r0 = dout_ready; e_r1 = 1'b0;
            end else if (m_own == 2) begin
                e_g = 2'b10; e_dv = din1_valid; e_data = din1_data;
                e_sop = din1_startofpacket; e_eop = din1_endofpacket;
                e_r0 = 1'b0; e_r1 = dout_ready;
            end else begin
                e_g = 2'b00; e_dv = 1'b0;
                e_r0 = !(din0_valid && din0_startofpacket);
                e_r1 = !(din1_valid && din1_startofpacket);
            end
            total++; if (grant !== e_g) begin bad++; $display("FAIL rnd_grant c%0d: got %b want %b", c, grant, e_g); end
            total++; if (dout_valid !== e_dv) begin bad++; $display("FAIL rnd_dv c%0d: got %b want %b", c, dout_valid, e_dv); end
            total++; if (din0_ready !== e_r0 || din1_ready !== e_r1) begin
                bad++; $display("FAIL rnd_ready c%0d: got %b%b want %b%b", c, din1_ready, din0_ready, e_r1, e_r0); end
            if (e_dv) begin
                total++; if (dout_data !== e_data || dout_startofpacket !== e_sop || dout_endofpacket !== e_eop) begin
                    bad++; $display("FAIL rnd_beat c%0d: got %h/%b/%b want %h/%b/%b", c, dout_data, dout_startofpacket, dout_endofpacket, e_data, e_sop, e_eop); end
            end
            total++; if (drop_cnt !== 16'(m_drop)) begin bad++; $display("FAIL rnd_drop c%0d: got %0d want %0d", c, drop_cnt, m_drop); end
            total++; if (video_width !== m_vw || video_height !== m_vh || video_interlaced !== m_vi) begin
                bad++; $display("FAIL rnd_video c%0d: got %0d/%0d/%0d want %0d/%0d/%0d", c, video_width, video_height, video_interlaced, m_vw, m_vh, m_vi); end
            // Advance the model for the coming edge
            if (m_own == 0) begin
                m_drop += int'(din0_valid && !din0_startofpacket) + int'(din1_valid && !din1_startofpacket);
                if (m_drop > 65535) m_drop = 65535;
                r0 = din0_valid && din0_startofpacket && (sel_mode == 2'd0 || sel_mode == 2'd1);
                r1 = din1_valid && din1_startofpacket && (sel_mode == 2'd0 || sel_mode == 2'd2);
                win = -1;
                if (r0 && r1) win = 1 - m_last;
                else if (r0) win = 0;
                else if (r1) win = 1;
                if (win == 0) begin
                    m_own = 1; m_last = 0; m_vw = s0_width; m_vh = s0_height; m_vi = s0_interlaced;
                end else if (win == 1) begin
                    m_own = 2; m_last = 1; m_vw = s1_width; m_vh = s1_height; m_vi = s1_interlaced;
                end
            end else if (m_own == 1) begin
                if (din0_valid && dout_ready && din0_endofpacket) m_own = 0;
            end else begin
                if (din1_valid && dout_ready && din1_endofpacket) m_own = 0;
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_round_robin();
        test_stray_beats();
        test_saturation();
        test_backpressure_mode();
        test_pause_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_stream_arbiter.md
VIDEO_STREAM_ARBITER -- requirements
Module: video_stream_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of every data bus; it must match the downstream blind_pixel_encode DATA_WIDTH.
REQ-002 SHALL have one clock and an asynchronous active-low reset.
REQ-003 SHALL provide the following ports, one per line.
- clk  in  1  the single clock.
- rst_n  in  1  asynchronous, active-low reset.
- sel_mode  in  2  0 = round-robin, 1 = source 0 only, 2 = source 1 only, 3 = pause.
- s0_width, s0_height  in  16 each  frame geometry of source 0.
- s0_interlaced  in  4  interlace nibble of source 0.
- s1_width, s1_height  in  16 each  frame geometry of source 1.
- s1_interlaced  in  4  interlace nibble of source 1.
- din0_data  in  DATA_WIDTH  source 0 pixel data.
- din0_valid, din0_startofpacket, din0_endofpacket  in  1 each  source 0 stream controls.
- din0_ready  out  1  source 0 backpressure.
- din1_*  (same five ports as din0_*)  source 1 stream.
- dout_data  out  DATA_WIDTH  merged stream data.
- dout_valid, dout_startofpacket, dout_endofpacket  out  1 each  merged stream controls.
- dout_ready  in  1  backpressure from the encoder.
- video_width, video_height  out  16 each  geometry of the granted frame.
- video_interlaced  out  4  interlace nibble of the granted frame.
- grant  out  2  one-hot owner: bit0 = source 0, bit1 = source 1, 00 = none.
- drop_cnt  out  16  count of discarded stray beats.

Function
REQ-004 SHALL use a state machine with one-hot states IDLE, GNT0 and GNT1.
REQ-005 Reset and default state SHALL be IDLE, with last-granted = source 1 so that source 0 wins the first tie.
REQ-006 In IDLE, source k SHALL request a grant when dink_valid and dink_startofpacket are both high. The request SHALL be masked by sel_mode as follows.
- Mode 1: only source 0 may request.
- Mode 2: only source 1 may request.
- Mode 3: no source may request.
REQ-007 With both sources requesting in mode 0, the grant SHALL go to the source that was not granted last.
REQ-008 On a grant, the next state SHALL be GNT0 or GNT1, and last-granted SHALL update.
REQ-009 On the clock edge entering GNTk, video_width, video_height and video_interlaced SHALL register sk_width, sk_height and sk_interlaced. These outputs SHALL be held until the next grant.
REQ-010 In IDLE, every source SHALL drive ready = 0 when its valid and startofpacket are both high. A SOP beat is therefore never consumed in IDLE and is held by its source.
REQ-011 In IDLE, a valid non-SOP beat on any source, in any mode, SHALL be accepted (ready = 1) and discarded.
REQ-012 Each discarded beat SHALL increment drop_cnt by 1, saturating at 16'hFFFF. Two simultaneous discards SHALL add 2, also saturating.
REQ-013 In IDLE, dout_valid SHALL be 0.
REQ-014 In GNTk, the block SHALL be a combinational pass-through with zero latency.
- dout_data, dout_valid, dout_startofpacket and dout_endofpacket SHALL equal the corresponding dink_* signals.
- dink_ready SHALL equal dout_ready.
- The other source's ready SHALL be 0.
REQ-015 In GNTk, the state SHALL return to IDLE on the edge where dink_valid, dout_ready and dink_endofpacket are all high. The first possible new grant is evaluated in the following cycle.
REQ-016 sel_mode SHALL be sampled only in IDLE. A mode change during GNTk SHALL NOT truncate the current packet.
REQ-017 A SOP arriving mid-packet in GNTk SHALL be passed through unchanged. Packet framing integrity is the source's duty.
REQ-018 grant SHALL reflect the state as a registered output: 01 in GNT0, 10 in GNT1, 00 in IDLE.
REQ-019 Minimum gap between two packets SHALL be one IDLE cycle, in which dout_valid = 0.

Reset
REQ-020 While rst_n is low, the block SHALL force the following, asynchronously:
- state = IDLE;
- grant = 00;
- video_width = video_height = 0;
- video_interlaced = 0;
- drop_cnt = 0;
- last-granted = source 1.
REQ-021 While rst_n is low, din0_ready, din1_ready and dout_valid SHALL evaluate per IDLE rules. Reset asserted mid-packet SHALL abandon the packet, and no beat SHALL be forwarded after the reset edge.

Verification
REQ-022 Single source: mode 0, src0 sends SOP plus 5 beats ending in EOP, s0_width = 640, s0_height = 480, dout_ready = 1 -> grant = 01 one cycle after SOP valid; 6 beats appear on dout unmodified; video_width = 640 and video_height = 480 on the SOP cycle; grant = 00 after the EOP.
REQ-023 Round-robin: mode 0, both sources hold SOP continuously -> grants alternate 01, 10, 01, each separated by one IDLE cycle.
REQ-024 Stray beats: in IDLE, src1 sends 3 valid non-SOP beats -> din1_ready = 1 on each, dout_valid = 0, drop_cnt = 3.
REQ-025 Backpressure and mode: in GNT0 with dout_ready toggling 1/0, set sel_mode = 2 mid-packet -> src0 packet completes intact and stalls exactly when dout_ready = 0; next grant = 10 even when src0 also requests.
REQ-026 Pause and reset: mode 3 with both SOPs pending -> grant stays 00 and both readys = 0; rst_n pulsed low mid-packet in GNT1 -> grant = 00, drop_cnt = 0 and video_* = 0 immediately.
